// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock and
// passes the carry between chunks through a register.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   in_valid   operands a, b, c_in, sub are valid
//   in_ready   block can accept operands (high only in idle)
//   a, b       WIDTH-bit operands
//   c_in       carry-in, add mode only
//   sub        0: a+b+c_in, 1: a-b computed as a+~b+1
//   out_valid  result valid
//   out_ready  consumer takes the result
//   s          WIDTH-bit sum/difference
//   c_out      carry out of bit WIDTH-1 (in sub mode, 1 = no borrow)
//   overflow   two's-complement signed overflow
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow
);

    // Guarded so a bad CHUNK reaches the error below instead of a divide by zero.
    localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || ((CHUNK == 0) ? 1'b1 : ((WIDTH % CHUNK) != 0)))
    begin : g_bad_params
        $error("chunked_serial_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    // Operands and result viewed as an array of chunks, indexed by the chunk counter.
    logic [NCHUNK-1:0][CHUNK-1:0] a_r, b_r, s_r;
    logic [IDXW-1:0]              idx_q;
    logic                         carry_q;
    logic                         c_out_q;
    logic                         ovf_q;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             top_carry_in;
    logic             last_chunk;

    // Chunk adder, CHUNK+1 bits wide so the top bit is the carry to the next chunk.
    always_comb begin
        a_chunk   = a_r[idx_q];
        b_chunk   = b_r[idx_q];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk's MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        top_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        last_chunk   = (idx_q == LAST_IDX);
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                if (last_chunk) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_r     <= a;
                        // Subtraction as a + ~b + 1: invert b, force carry-in to 1.
                        b_r     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : c_in;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    s_r[idx_q] <= chunk_sum[CHUNK-1:0];
                    carry_q    <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        c_out_q <= chunk_sum[CHUNK];
                        ovf_q   <= top_carry_in ^ chunk_sum[CHUNK];
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s        = s_r;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: scoreboard bench for chunked_serial_adder. Expected results come from
// a plain-arithmetic model and are queued at accept; a negedge monitor pops and compares them
// whenever a result handshake is about to happen.
module tb_chunked_serial_adder;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CHUNK   = 4;
    localparam int unsigned NCHUNK  = WIDTH / CHUNK;
    localparam int          TIMEOUT = 200;
    localparam int          NDIR    = 8;
    localparam int          NRAND   = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } result_t;

    result_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    logic [15:0] dir_a   [NDIR] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF,
                                    16'h8000, 16'h0005, 16'h8000, 16'h1234};
    logic [15:0] dir_b   [NDIR] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001,
                                    16'h8000, 16'h0007, 16'h0001, 16'h0000};
    logic        dir_cin [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        dir_sub [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    chunked_serial_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got no event, required one within %0d cycles", name, TIMEOUT);
    endtask

    // Reference: unsigned and signed interpretations computed with 64-bit integers.
    function automatic result_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                      input logic tc, input logic ts);
        longint  modv, ua, ub, sa, sb, r, sr;
        result_t res;
        modv = longint'(1) << WIDTH;
        ua   = longint'(ta);
        ub   = longint'(tb_v);
        sa   = ta[WIDTH-1] ? ua - modv : ua;
        sb   = tb_v[WIDTH-1] ? ub - modv : ub;
        if (ts) begin
            r     = ua - ub;
            sr    = sa - sb;
            res.c = (ua >= ub);
        end else begin
            r     = ua + ub + longint'(tc);
            sr    = sa + sb + longint'(tc);
            res.c = (r >= modv);
        end
        res.s = WIDTH'(r);
        res.v = (sr > modv / 2 - 1) || (sr < -(modv / 2));
        return res;
    endfunction

    // Monitor: a result is consumed at the next posedge when out_valid && out_ready now.
    always @(negedge clk) begin
        result_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got s=0x%0h, required no result", s);
            end else begin
                e = exp_q.pop_front();
                check("result_s", 64'(s), 64'(e.s));
                check("result_c_out", 64'(c_out), 64'(e.c));
                check("result_overflow", 64'(overflow), 64'(e.v));
            end
        end
    end

    // Called at posedge+1; returns at accept edge +1 with in_valid dropped.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input logic ts, output bit accepted);
        int n;
        a        = ta;
        b        = tb_v;
        c_in     = tc;
        sub      = ts;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        accepted = in_ready;
        if (!accepted) fail("accept_timeout");
        else exp_q.push_back(model(ta, tb_v, tc, ts));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Post-accept input changes must not affect the operation.
        a    = WIDTH'($urandom);
        b    = WIDTH'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    task automatic wait_latency();
        int e;
        e = 0;
        while (!out_valid && e < TIMEOUT) begin
            @(posedge clk);
            #1;
            e++;
        end
        if (!out_valid) fail("out_valid_timeout");
        else check("latency", 64'(e), 64'(NCHUNK));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) fail("idle_timeout");
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tc, input logic ts);
        bit acc;
        issue(ta, tb_v, tc, ts, acc);
        if (acc) begin
            wait_latency();
            wait_idle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required one before 1 ms");
        $fatal(1);
    end

    initial begin
        bit      acc;
        result_t bp;
        int      mid;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_s", 64'(s), 64'd0);
        check("reset_c_out", 64'(c_out), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        for (int i = 0; i < NDIR; i++) begin
            run_op(WIDTH'(dir_a[i]), WIDTH'(dir_b[i]), dir_cin[i], dir_sub[i]);
        end

        // Backpressure: result must hold and nothing may be accepted.
        out_ready = 1'b0;
        bp = model(WIDTH'(16'h7FFF), WIDTH'(16'h0001), 1'b0, 1'b0);
        issue(WIDTH'(16'h7FFF), WIDTH'(16'h0001), 1'b0, 1'b0, acc);
        if (acc) begin
            wait_latency();
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                in_valid = ~in_valid;
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                c_in     = 1'($urandom);
                sub      = 1'($urandom);
                @(negedge clk);
                check("bp_s", 64'(s), 64'(bp.s));
                check("bp_c_out", 64'(c_out), 64'(bp.c));
                check("bp_overflow", 64'(overflow), 64'(bp.v));
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("release_in_ready", 64'(in_ready), 64'd1);
            check("release_out_valid", 64'(out_valid), 64'd0);
        end

        // Reset mid-run: assert so it is sampled after two chunks (or sooner for short ops).
        mid = (NCHUNK > 2) ? 2 : int'(NCHUNK) - 1;
        issue(WIDTH'(16'h0F0F), WIDTH'(16'h0101), 1'b0, 1'b0, acc);
        if (acc) begin
            repeat (mid) @(posedge clk);
            #1;
            reset = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            check("midrst_s", 64'(s), 64'd0);
            check("midrst_in_ready", 64'(in_ready), 64'd1);
            check("midrst_c_out", 64'(c_out), 64'd0);
        end
        run_op(WIDTH'(16'h00FF), WIDTH'(16'h0001), 1'b0, 1'b0);

        for (int i = 0; i < NRAND; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
